// File: rtl/queue_flex_if.sv
// Producer/consumer handshake bundle for queue_flex: enq/din in, deq/dout out, plus status.
// The queue itself connects through the slave modport.
interface queue_flex_if #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  enq;
  logic [DATA_WIDTH-1:0] din;
  logic                  enq_ready;
  logic                  deq;
  logic                  deq_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output flush, enq, din, deq,
    input  enq_ready, deq_valid, dout, count,
    input  almost_full, almost_empty, err_ovf, err_udf
  );

  modport slave (
    input  flush, enq, din, deq,
    output enq_ready, deq_valid, dout, count,
    output almost_full, almost_empty, err_ovf, err_udf
  );
endinterface

// File: rtl/queue_flex.sv
// Parametrised synchronous FIFO with show-ahead output, optional pipe mode, flush,
// occupancy count, almost-full/empty decode and sticky overflow/underflow flags.
module queue_flex #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 2,
  parameter int PIPE       = 0,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic          clk,
  input  logic          rst,
  queue_flex_if.slave   q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  err_ovf;
  logic                  err_udf;
  logic                  full;
  logic                  empty;
  logic                  enq_ready;
  logic                  deq_valid;
  logic                  enq_fire;
  logic                  deq_fire;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1))
      return '0;
    else
      return p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] c,
                                               input logic e, input logic d);
    case ({e, d})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign deq_valid = !empty;
  assign enq_ready = !full || ((PIPE != 0) && q.deq);
  assign enq_fire  = q.enq && enq_ready;
  assign deq_fire  = q.deq && deq_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // In pipe mode at full, wr_ptr equals rd_ptr, so the write lands in the slot being popped.
      if (enq_fire) begin
        mem[wr_ptr] <= q.din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (deq_fire)
        rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next(count, enq_fire, deq_fire);
      if (q.enq && !enq_ready)
        err_ovf <= 1'b1;
      if (q.deq && !deq_valid)
        err_udf <= 1'b1;
    end
  end

  assign q.enq_ready    = enq_ready;
  assign q.deq_valid    = deq_valid;
  assign q.dout         = mem[rd_ptr];
  assign q.count        = count;
  assign q.almost_full  = (int'(count) >= AF_LEVEL);
  assign q.almost_empty = (int'(count) <= AE_LEVEL);
  assign q.err_ovf      = err_ovf;
  assign q.err_udf      = err_udf;
endmodule

// File: tb/tb_queue_flex.sv
// Bench for queue_flex: three instances (D2/P0, D3/P0, D2/P1) share one stimulus stream and
// are checked each cycle against an ordered-list model, plus literal expectations.
module tb_queue_flex;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       enq_i = 1'b0;
  logic       deq_i = 1'b0;
  logic [3:0] din_i = 4'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  queue_flex_if #(.DATA_WIDTH(4), .DEPTH(2)) ifa ();
  queue_flex_if #(.DATA_WIDTH(4), .DEPTH(3)) ifb ();
  queue_flex_if #(.DATA_WIDTH(4), .DEPTH(2)) ifc ();

  assign ifa.flush = flush_i; assign ifa.enq = enq_i; assign ifa.deq = deq_i; assign ifa.din = din_i;
  assign ifb.flush = flush_i; assign ifb.enq = enq_i; assign ifb.deq = deq_i; assign ifb.din = din_i;
  assign ifc.flush = flush_i; assign ifc.enq = enq_i; assign ifc.deq = deq_i; assign ifc.din = din_i;

  queue_flex #(.DATA_WIDTH(4), .DEPTH(2), .PIPE(0)) dut_a (.clk(clk), .rst(rst_i), .q(ifa));
  queue_flex #(.DATA_WIDTH(4), .DEPTH(3), .PIPE(0)) dut_b (.clk(clk), .rst(rst_i), .q(ifb));
  queue_flex #(.DATA_WIDTH(4), .DEPTH(2), .PIPE(1)) dut_c (.clk(clk), .rst(rst_i), .q(ifc));

  logic [3:0] o_dout [3];
  logic [1:0] o_count [3];
  logic       o_dv [3], o_er [3], o_af [3], o_ae [3], o_ovf [3], o_udf [3];

  assign o_dout[0] = ifa.dout;  assign o_dout[1] = ifb.dout;  assign o_dout[2] = ifc.dout;
  assign o_count[0] = ifa.count; assign o_count[1] = ifb.count; assign o_count[2] = ifc.count;
  assign o_dv[0] = ifa.deq_valid; assign o_dv[1] = ifb.deq_valid; assign o_dv[2] = ifc.deq_valid;
  assign o_er[0] = ifa.enq_ready; assign o_er[1] = ifb.enq_ready; assign o_er[2] = ifc.enq_ready;
  assign o_af[0] = ifa.almost_full; assign o_af[1] = ifb.almost_full; assign o_af[2] = ifc.almost_full;
  assign o_ae[0] = ifa.almost_empty; assign o_ae[1] = ifb.almost_empty; assign o_ae[2] = ifc.almost_empty;
  assign o_ovf[0] = ifa.err_ovf; assign o_ovf[1] = ifb.err_ovf; assign o_ovf[2] = ifc.err_ovf;
  assign o_udf[0] = ifa.err_udf; assign o_udf[1] = ifb.err_udf; assign o_udf[2] = ifc.err_udf;

  // Model: per instance, an ordered list of stored words (index 0 is the head).
  int         mdep [3]  = '{2, 3, 2};
  bit         mpipe [3] = '{1'b0, 1'b0, 1'b1};
  int         mcnt [3]  = '{0, 0, 0};
  logic [3:0] mdat [3][4];
  bit         movf [3]  = '{1'b0, 1'b0, 1'b0};
  bit         mudf [3]  = '{1'b0, 1'b0, 1'b0};
  bit         mfresh [3] = '{1'b1, 1'b1, 1'b1};
  bit         mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_i) begin
        mcnt[k] = 0; movf[k] = 1'b0; mudf[k] = 1'b0; mfresh[k] = 1'b1;
      end else if (flush_i) begin
        mcnt[k] = 0;
      end else begin
        bit ready, valid, ef, df;
        ready = (mcnt[k] != mdep[k]) || (mpipe[k] && deq_i);
        valid = (mcnt[k] != 0);
        ef = enq_i && ready;
        df = deq_i && valid;
        if (enq_i && !ready) movf[k] = 1'b1;
        if (deq_i && !valid) mudf[k] = 1'b1;
        if (df) begin
          for (int j = 0; j < 3; j++) mdat[k][j] = mdat[k][j+1];
          mcnt[k]--;
        end
        if (ef) begin
          mdat[k][mcnt[k]] = din_i;
          mcnt[k]++;
          mfresh[k] = 1'b0;
        end
      end
    end
    if (rst_i) mon_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("count%0d", k), 32'(o_count[k]), 32'(mcnt[k]));
        chk($sformatf("deq_valid%0d", k), 32'(o_dv[k]), 32'(mcnt[k] != 0));
        chk($sformatf("enq_ready%0d", k), 32'(o_er[k]),
            32'((mcnt[k] != mdep[k]) || (mpipe[k] && deq_i)));
        chk($sformatf("almost_full%0d", k), 32'(o_af[k]), 32'(mcnt[k] >= mdep[k] - 1));
        chk($sformatf("almost_empty%0d", k), 32'(o_ae[k]), 32'(mcnt[k] <= 1));
        chk($sformatf("err_ovf%0d", k), 32'(o_ovf[k]), 32'(movf[k]));
        chk($sformatf("err_udf%0d", k), 32'(o_udf[k]), 32'(mudf[k]));
        if (mcnt[k] != 0)
          chk($sformatf("dout%0d", k), 32'(o_dout[k]), 32'(mdat[k][0]));
        else if (mfresh[k])
          chk($sformatf("dout_rst%0d", k), 32'(o_dout[k]), 32'h0);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic e, input logic d,
                     input logic [3:0] x);
    rst_i = r; flush_i = f; enq_i = e; deq_i = d; din_i = x;
    @(posedge clk); #1;
    rst_i = 1'b0; flush_i = 1'b0; enq_i = 1'b0; deq_i = 1'b0;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_dout", 32'(ifa.dout), 0);
    chk("rst_dv", 32'(ifa.deq_valid), 0);
    chk("rst_er", 32'(ifa.enq_ready), 1);
    chk("rst_ae", 32'(ifa.almost_empty), 1);
    chk("rst_af", 32'(ifa.almost_full), 0);
    chk("rst_count", 32'(ifa.count), 0);

    cyc(0, 0, 1, 0, 4'h1);
    chk("e1_dv", 32'(ifa.deq_valid), 1);
    chk("e1_er", 32'(ifa.enq_ready), 1);
    chk("e1_dout", 32'(ifa.dout), 1);
    chk("e1_count", 32'(ifa.count), 1);
    cyc(0, 0, 1, 0, 4'h2);
    chk("e2_er", 32'(ifa.enq_ready), 0);
    chk("e2_count", 32'(ifa.count), 2);
    chk("e2_af", 32'(ifa.almost_full), 1);
    chk("e2_dout", 32'(ifa.dout), 1);

    cyc(0, 0, 0, 1, 0);
    chk("d1_dout", 32'(ifa.dout), 2);
    chk("d1_er", 32'(ifa.enq_ready), 1);
    chk("d1_count", 32'(ifa.count), 1);
    cyc(0, 0, 0, 1, 0);
    chk("d2_dv", 32'(ifa.deq_valid), 0);
    chk("d2_count", 32'(ifa.count), 0);
    chk("d2_ae", 32'(ifa.almost_empty), 1);
    chk("d2_udf", 32'(ifa.err_udf), 0);

    // Overflow at full without a pop: only the depth-3 instance takes the third word.
    cyc(0, 0, 1, 0, 4'h3);
    cyc(0, 0, 1, 0, 4'h4);
    cyc(0, 0, 1, 0, 4'h5);
    chk("ovf_a_count", 32'(ifa.count), 2);
    chk("ovf_a_dout", 32'(ifa.dout), 3);
    chk("ovf_a_flag", 32'(ifa.err_ovf), 1);
    chk("ovf_b_count", 32'(ifb.count), 3);
    chk("ovf_b_flag", 32'(ifb.err_ovf), 0);
    chk("ovf_c_flag", 32'(ifc.err_ovf), 1);

    // Full with simultaneous push and pop: pipe instance accepts both.
    cyc(0, 0, 1, 1, 4'h6);
    chk("pipe_c_count", 32'(ifc.count), 2);
    chk("pipe_c_dout", 32'(ifc.dout), 4);
    chk("pipe_a_count", 32'(ifa.count), 1);
    chk("pipe_a_ovf", 32'(ifa.err_ovf), 1);
    cyc(0, 0, 0, 1, 0);
    chk("pipe_c_last", 32'(ifc.dout), 6);
    chk("pipe_b_dout", 32'(ifb.dout), 5);

    // Interleaved push/pop through the depth-3 pointer wrap.
    cyc(1, 0, 0, 0, 0);
    chk("rst2_ovf", 32'(ifa.err_ovf), 0);
    cyc(0, 0, 1, 0, 4'hA);
    cyc(0, 0, 1, 0, 4'hB);
    chk("model_b_cnt", 32'(mcnt[1]), 2);
    cyc(0, 0, 0, 1, 0);
    chk("il_b", 32'(ifb.dout), 4'hB);
    cyc(0, 0, 1, 0, 4'hC);
    cyc(0, 0, 0, 1, 0);
    chk("il_c", 32'(ifb.dout), 4'hC);
    cyc(0, 0, 1, 0, 4'hD);
    cyc(0, 0, 0, 1, 0);
    chk("il_d", 32'(ifb.dout), 4'hD);
    cyc(0, 0, 1, 0, 4'hE);
    cyc(0, 0, 0, 1, 0);
    chk("il_e", 32'(ifb.dout), 4'hE);
    chk("il_a_e", 32'(ifa.dout), 4'hE);
    chk("model_b_head", 32'(mdat[1][0]), 4'hE);
    cyc(0, 0, 0, 1, 0);
    chk("il_empty", 32'(ifb.deq_valid), 0);

    // Underflow, then flush with a discarded enq; flags must survive the flush.
    cyc(0, 0, 0, 1, 0);
    chk("udf_flag", 32'(ifa.err_udf), 1);
    cyc(0, 0, 1, 0, 4'h8);
    cyc(0, 0, 1, 0, 4'h9);
    cyc(0, 1, 1, 0, 4'h7);
    chk("fl_count", 32'(ifa.count), 0);
    chk("fl_dv", 32'(ifa.deq_valid), 0);
    chk("fl_er", 32'(ifa.enq_ready), 1);
    chk("fl_udf", 32'(ifa.err_udf), 1);
    chk("fl_ovf", 32'(ifa.err_ovf), 0);
    chk("model_fl_cnt", 32'(mcnt[0]), 0);
    cyc(0, 0, 1, 0, 4'h1);
    chk("fl_next", 32'(ifa.dout), 1);

    // Reset mid-operation with an enq in the same cycle.
    cyc(1, 0, 1, 0, 4'hF);
    chk("mr_count", 32'(ifa.count), 0);
    chk("mr_dout", 32'(ifa.dout), 0);
    chk("mr_udf", 32'(ifa.err_udf), 0);
    cyc(0, 0, 0, 0, 0);
    chk("mr_dout2", 32'(ifb.dout), 0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      cyc((r[7:2] == 6'h3F), (r[7:4] == 4'h5), r[0], r[1], 4'($urandom));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
